// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: funct3 encodings and controller states.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/branch_taken_decode.sv
// Combinational branch condition decode: funct3 plus comparator flags to
// taken/illegal, and the unsigned-compare select fed back to the comparator.
module branch_taken_decode
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       breq,
  input  logic       brlt,
  output logic       taken,
  output logic       illegal,
  output logic       brun
);

  // Map each branch kind onto the equality or less-than flag; 010/011 are illegal.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    brun    = 1'b0;
    case (funct3)
      BEQ:  taken = breq;
      BNE:  taken = !breq;
      BLT:  taken = brlt;
      BGE:  taken = !brlt;
      BLTU: begin
        taken = brlt;
        brun  = 1'b1;
      end
      BGEU: begin
        taken = !brlt;
        brun  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution controller: accepts a branch, decides taken, issues a
// registered redirect to fetch, then holds a flush window. Counts branches.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  output logic             brun,
  input  logic             breq,
  input  logic             brlt,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  state_e            state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              illegal_q, illegal_d;
  logic              misaligned_q, misaligned_d;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic              dec_taken;
  logic              dec_illegal;
  logic              accept;
  logic [XLEN-1:0]   target;

  branch_taken_decode u_decode (
    .funct3  (funct3),
    .breq    (breq),
    .brlt    (brlt),
    .taken   (dec_taken),
    .illegal (dec_illegal),
    .brun    (brun)
  );

  // Outputs that depend only on the registered state, so reset clears them at once.
  assign br_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == FLUSH);
  assign accept         = br_valid && br_ready;
  assign target         = pc + imm;

  assign redirect_pc  = redirect_pc_q;
  assign illegal      = illegal_q;
  assign misaligned   = misaligned_q;
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;

  // Next-state logic: accept/classify in IDLE, handshake in REDIRECT, countdown in FLUSH.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_pc_d  = redirect_pc_q;
    illegal_d      = 1'b0;
    misaligned_d   = 1'b0;
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else begin
            branch_count_d = branch_count_q + CNT_W'(1);
            if (dec_taken) begin
              if (target[1]) begin
                misaligned_d = 1'b1;
              end else begin
                redirect_pc_d = target;
                state_d       = REDIRECT;
              end
            end
          end
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          taken_count_d = taken_count_q + CNT_W'(1);
          flush_cnt_d   = 4'(FLUSH_CYCLES);
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= 4'd1) begin
          flush_cnt_d = 4'd0;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      flush_cnt_q    <= 4'd0;
      redirect_pc_q  <= '0;
      illegal_q      <= 1'b0;
      misaligned_q   <= 1'b0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_pc_q  <= redirect_pc_d;
      illegal_q      <= illegal_d;
      misaligned_q   <= misaligned_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios then random traffic, all
// checked against an operand-level reference model of branch behaviour.
module tb_branch_resolve;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk;
  logic             rst;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             brun;
  logic             breq;
  logic             brlt;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             illegal;
  logic             misaligned;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  int checks;
  int errors;

  // Reference model: what the controller is doing, in terms of pending work.
  logic        mPending;
  int          mFlushLeft;
  logic [31:0] mTarget;
  logic        mIllegal;
  logic        mMis;
  logic [31:0] mBranches;
  logic [31:0] mTaken;
  logic        mBrun;

  branch_resolve #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .funct3         (funct3),
    .pc             (pc),
    .imm            (imm),
    .brun           (brun),
    .breq           (breq),
    .brlt           (brlt),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .illegal        (illegal),
    .misaligned     (misaligned),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPending   = 1'b0;
    mFlushLeft = 0;
    mTarget    = '0;
    mIllegal   = 1'b0;
    mMis       = 1'b0;
    mBranches  = '0;
    mTaken     = '0;
  endtask

  task automatic checkOutput();
    logic expReady;
    expReady = !mPending && (mFlushLeft == 0);
    checkOne("br_ready", {31'd0, br_ready}, {31'd0, expReady});
    checkOne("brun", {31'd0, brun}, {31'd0, mBrun});
    checkOne("redirect_valid", {31'd0, redirect_valid}, {31'd0, mPending});
    checkOne("redirect_pc", redirect_pc, mTarget);
    checkOne("flush", {31'd0, flush}, {31'd0, (mFlushLeft > 0)});
    checkOne("illegal", {31'd0, illegal}, {31'd0, mIllegal});
    checkOne("misaligned", {31'd0, misaligned}, {31'd0, mMis});
    checkOne("branch_count", branch_count, mBranches);
    checkOne("taken_count", taken_count, mTaken);
  endtask

  // Branch outcome from the real operands, as the ISA defines it.
  function automatic logic isaTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelStep(input logic v, input logic [2:0] f3, input logic [31:0] p,
                           input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic rr);
    logic [31:0] tgt;
    mIllegal = 1'b0;
    mMis     = 1'b0;
    if (mPending) begin
      if (rr) begin
        mPending   = 1'b0;
        mTaken     = mTaken + 1;
        mFlushLeft = FLUSH_CYCLES;
      end
    end else if (mFlushLeft > 0) begin
      mFlushLeft = mFlushLeft - 1;
    end else if (v) begin
      if (f3 == 3'd2 || f3 == 3'd3) begin
        mIllegal = 1'b1;
      end else begin
        mBranches = mBranches + 1;
        tgt = p + i;
        if (isaTaken(f3, a, b)) begin
          if (tgt[1]) begin
            mMis = 1'b1;
          end else begin
            mPending = 1'b1;
            mTarget  = tgt;
          end
        end
      end
    end
  endtask

  // Drive one cycle at the falling edge, acting as branch_comp for the operands.
  task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [31:0] p,
                               input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                               input logic rr);
    br_valid       = v;
    funct3         = f3;
    pc             = p;
    imm            = i;
    redirect_ready = rr;
    mBrun          = (f3 == 3'd6) || (f3 == 3'd7);
    breq           = (a == b);
    brlt           = mBrun ? (a < b) : ($signed(a) < $signed(b));
    #1;
    checkOutput();
    modelStep(v, f3, p, i, a, b, rr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 32'h1, 32'h2, rr);
  endtask

  initial begin
    logic        rv;
    logic [2:0]  rf3;
    logic [31:0] rp, ri, ra, rb;
    logic        rr;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    br_valid = 1'b0; funct3 = 3'd0; pc = '0; imm = '0;
    breq = 1'b0; brlt = 1'b0; redirect_ready = 1'b0;
    modelReset();
    mBrun = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] BEQ taken with fetch ready");
    applyStimulus(1'b1, 3'd0, 32'h100, 32'h20, 32'h5, 32'h5, 1'b1);
    idle(5, 1'b1);

    $display("[TB] BGEU not taken then BLT taken back-to-back");
    applyStimulus(1'b1, 3'd7, 32'h200, 32'h40, 32'h1, 32'h2, 1'b1);
    applyStimulus(1'b1, 3'd4, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 1'b1);
    idle(4, 1'b1);

    $display("[TB] BNE taken with fetch stalled, extra branch offered");
    applyStimulus(1'b1, 3'd1, 32'h400, 32'hFFFF_FF00, 32'h3, 32'h4, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 3'd0, 32'h800, 32'h8, 32'h7, 32'h7, 1'b0);
    idle(4, 1'b1);

    $display("[TB] target wrap");
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h9, 32'h9, 1'b1);
    idle(4, 1'b1);

    $display("[TB] illegal funct3");
    applyStimulus(1'b1, 3'd2, 32'h500, 32'h10, 32'h1, 32'h1, 1'b1);
    applyStimulus(1'b1, 3'd3, 32'h500, 32'h10, 32'h1, 32'h1, 1'b1);
    idle(2, 1'b1);

    $display("[TB] misaligned target");
    applyStimulus(1'b1, 3'd0, 32'h100, 32'h2, 32'h6, 32'h6, 1'b1);
    idle(2, 1'b1);

    $display("[TB] reset during flush");
    applyStimulus(1'b1, 3'd5, 32'h600, 32'h80, 32'h8, 32'h3, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 32'h1, 32'h2, 1'b1);
    checkOne("flush_before_reset", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rf3 = 3'($urandom_range(0, 7));
      rp  = $urandom() & 32'hFFFF_FFFC;
      ri  = $urandom() & 32'hFFFF_FFFE;
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      rr  = ($urandom_range(0, 2) != 0);
      applyStimulus(rv, rf3, rp, ri, ra, rb, rr);
    end
    idle(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
